// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- front-panel sequencer for the single-digit stopwatch.
// Synchronizes and debounces the St/Stp/Clr push-buttons (all active-low),
// runs the IDLE/RUN/PAUSE state machine, owns the tick prescaler and issues
// one-cycle cnt_en / cnt_clr strobes to the BCD digit counter.
// Optional feature: define STOPWATCH_AUTOSTOP_EN to add the DONE state
// (stop at the terminal count when cnt_val == LIMIT). Without the macro the
// block has no DONE state, done is tied 0 and the counter wraps by itself.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DBNC_CYC = 500_000,
    parameter int LIMIT    = 9
) (
    input  logic       Clk,
    input  logic       R,
    input  logic       St,
    input  logic       Stp,
    input  logic       Clr,
    input  logic [3:0] cnt_val,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       running,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DBNC_CYC > 0) ? $clog2(DBNC_CYC + 1) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DBNC_LAST = DW'(DBNC_CYC - 1);

    // Button lane indices inside the packed vectors below.
    localparam int BTN_ST  = 0;
    localparam int BTN_STP = 1;
    localparam int BTN_CLR = 2;

`ifdef STOPWATCH_AUTOSTOP_EN
    localparam logic [3:0] LIMIT_V = 4'(LIMIT);
`else
    // cnt_val and LIMIT only matter for autostop builds.
    logic unused_cnt_val_s;
    assign unused_cnt_val_s = ^{cnt_val, 4'(LIMIT)};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
`ifdef STOPWATCH_AUTOSTOP_EN
        ,
        S_DONE  = 2'd3
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizers and debouncers (one lane per button)
    // ------------------------------------------------------------------
    logic [2:0]          btn_s;
    logic [2:0]          sync1_q, sync1_d;
    logic [2:0]          sync2_q, sync2_d;
    logic [2:0]          lvl_q, lvl_d;          // debounced level, 1 = released
    logic [2:0]          lvl_dly_q, lvl_dly_d;  // previous debounced level
    logic [2:0]          ev_q, ev_d;            // one-cycle press events
    logic [2:0][DW-1:0]  stab_q, stab_d;

    assign btn_s = {Clr, Stp, St};

    // Debounce: count cycles the synchronized level differs from the accepted
    // level; any return to the accepted level restarts the count.
    always_comb begin
        sync1_d   = btn_s;
        sync2_d   = sync1_q;
        lvl_d     = lvl_q;
        lvl_dly_d = lvl_q;
        stab_d    = stab_q;
        // Press event is the registered 1->0 edge of the debounced level.
        ev_d      = lvl_dly_q & ~lvl_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == lvl_q[i]) begin
                stab_d[i] = '0;
            end else if (stab_q[i] == DBNC_LAST) begin
                stab_d[i] = '0;
                lvl_d[i]  = sync2_q[i];
            end else begin
                stab_d[i] = stab_q[i] + DW'(1);
            end
        end
    end

    // Debouncer registers; reset treats every button as released.
    always_ff @(posedge Clk) begin
        if (!R) begin
            sync1_q   <= 3'b111;
            sync2_q   <= 3'b111;
            lvl_q     <= 3'b111;
            lvl_dly_q <= 3'b111;
            ev_q      <= 3'b000;
            stab_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_dly_d;
            ev_q      <= ev_d;
            stab_q    <= stab_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer and prescaler
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic           cnt_en_q, cnt_en_d;
    logic           cnt_clr_q, cnt_clr_d;
    logic           running_q, running_d;
    logic           done_q, done_d;
    logic           tc_s;

    // Next state, prescaler and strobes; Clr beats Stp beats St.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        tc_s      = (state_q == S_RUN) && (pre_q == TICK_LAST);

        // Prescaler counts only in RUN, holds in PAUSE so a resume keeps the
        // fraction of the current tick, and is parked at 0 otherwise.
        case (state_q)
            S_RUN: begin
                if (tc_s) begin
                    pre_d = '0;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            S_PAUSE: pre_d = pre_q;
            default: pre_d = '0;
        endcase

        if (ev_q[BTN_CLR]) begin
            // Clear wins over everything, including a coincident tick.
            state_d   = S_IDLE;
            pre_d     = '0;
            cnt_clr_d = 1'b1;
        end
`ifdef STOPWATCH_AUTOSTOP_EN
        else if (tc_s && (cnt_val == LIMIT_V)) begin
            // Terminal digit reached: withhold the tick and stop.
            state_d = S_DONE;
        end
`endif
        else begin
            cnt_en_d = tc_s;
            case (state_q)
                S_RUN: begin
                    if (ev_q[BTN_STP]) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_IDLE, S_PAUSE: begin
                    if (ev_q[BTN_ST]) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        running_d = (state_d == S_RUN);
`ifdef STOPWATCH_AUTOSTOP_EN
        done_d = (state_d == S_DONE);
`else
        done_d = 1'b0;
`endif
    end

    // State, prescaler and registered outputs; reset holds the counter clear.
    always_ff @(posedge Clk) begin
        if (!R) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign cnt_en  = cnt_en_q;
    assign cnt_clr = cnt_clr_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the single-digit 0–9 stopwatch counter. It debounces the three front-panel push-buttons and runs an IDLE/RUN/PAUSE state machine. It owns the tick prescaler and issues one-cycle `cnt_en`/`cnt_clr` strobes to the BCD digit counter, which then drives the hex display. Button handling and timing move out of the counter datapath into one fully synchronous block.

## Interface
- `TICK_DIV`, default 50_000_000: Clk cycles per count tick (1 Hz at 50 MHz); must be ≥2.
- `DBNC_CYC`, default 500_000: cycles a synchronized button level must be stable before acceptance (10 ms); must be ≥1.
- `LIMIT`, default 9: terminal digit value used by autostop.
- `Clk` in 1: system clock; all logic on posedge.
- `R` in 1: reset, synchronous, active-low.
- `St` in 1: start button, active-low, asynchronous to Clk.
- `Stp` in 1: stop/pause button, active-low, asynchronous.
- `Clr` in 1: clear button, active-low, asynchronous.
- `cnt_val` in 4: current digit value from the counter (used only with autostop).
- `cnt_en` out 1: one-cycle increment strobe to the counter.
- `cnt_clr` out 1: clear strobe to the counter.
- `running` out 1: high while the state is RUN.
- `done` out 1: high while the state is DONE (autostop builds only; tied 0 otherwise).

## Operation
- **Button synchronization:** each button passes through a 2-FF synchronizer, then an independent debouncer.
- **Debouncer:**
  - A stable counter resets on any change of the synchronized level.
  - Once the level has been unchanged for DBNC_CYC cycles, it becomes the debounced level.
  - A 1→0 transition of the debounced level produces exactly one press event, one cycle wide.
  - Release produces no event.
  - Holding a button yields one event only.
- **States:** IDLE (reset state), RUN, PAUSE, and DONE (macro only).
- **Transitions:**
  - Clr event, any state → IDLE, with a `cnt_clr` pulse.
  - Stp event: RUN → PAUSE.
  - St event: IDLE → RUN, PAUSE → RUN.
  - St while in RUN is ignored. Stp while in IDLE, PAUSE or DONE is ignored.
- **Event priority in the same cycle:** Clr > Stp > St.
- **Prescaler:**
  - Counter width is ceil(log2(TICK_DIV)).
  - Increments only in RUN.
  - At TICK_DIV−1 it wraps to 0, and `cnt_en`=1 for that cycle.
  - Holds its value in PAUSE, so fractional time is preserved across pause/resume.
  - Forced to 0 in IDLE and DONE.
- **Outputs:** all registered. `cnt_en` and `cnt_clr` are never high in the same cycle.

## Timing
- **Reset:** while R=0 at a posedge, the next state is IDLE.
  - Prescaler and debouncers go to 0. Debounced levels go to 1 (released).
  - `cnt_en`=0, `cnt_clr`=1, `running`=0, `done`=0.
  - `cnt_clr` falls the first cycle after R returns high.
- **Button latency:** a press event is asserted DBNC_CYC+2 cycles after the first Clk edge that samples the pin low. The state and `running` update on the following edge.
- **Clear pulse:** `cnt_clr` is high for exactly one cycle, the cycle after the Clr event.
- **Tick rate:** in uninterrupted RUN, `cnt_en` pulses every TICK_DIV cycles. The first pulse after IDLE→RUN is TICK_DIV cycles after `running` rises.
- **Stp coincident with terminal count:** the tick is still issued (`cnt_en`=1), the state goes to PAUSE, and the prescaler holds 0.
- **Clr coincident with terminal count:** `cnt_en` is suppressed and only `cnt_clr` pulses.
- **Reset mid-RUN or mid-debounce:** all state is discarded; no pending event survives reset.

## Configuration
- **`STOPWATCH_AUTOSTOP_EN` defined:**
  - At a RUN terminal count with `cnt_val`==LIMIT, `cnt_en` is suppressed and the state goes to DONE (`running`=0, `done`=1).
  - In DONE, St and Stp are ignored; only Clr (→IDLE) or reset exits.
- **Macro undefined:**
  - No DONE state; `done` is tied 0.
  - `cnt_en` is issued regardless of `cnt_val`, and the counter wraps 9→0 by itself.

## Test plan
All scenarios use TICK_DIV=4, DBNC_CYC=3, LIMIT=9.

1. Hold R=0 for 2 cycles, then release → `cnt_clr`=1 during reset, then 0. After release: `running`=0, `cnt_en`=0, `done`=0.
2. Press St low for 10 cycles, then run 16 cycles → `running` rises 6 cycles after St is first sampled low. Four `cnt_en` pulses follow, exactly 4 cycles apart.
3. While running, press Stp 1 cycle after a tick, hold 6 cycles, then press St → `running`=0 with no `cnt_en` while paused. After resume, the first `cnt_en` arrives 4 cycles minus the elapsed pre-pause count (prescaler held).
4. Bounce St (low 2 cycles, high 1, low 2) → no event. Then hold low 5 cycles → exactly one event.
5. Assert Clr and Stp events in the same cycle during RUN, on the terminal count → `cnt_en`=0, one `cnt_clr` pulse, state IDLE.
6. Autostop build: RUN with `cnt_val`=9 at terminal count → no `cnt_en`, `done`=1. St is ignored; Clr → `done`=0 with a `cnt_clr` pulse. Non-macro build, same stimulus → `cnt_en`=1.
